load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Sequential load-return unit for the pipelined RV32I core with exception/interrupt support.
- Accepts a load request (byte address plus extension op) from the MEM stage and issues word-aligned reads on the data bus.
- Extracts the addressed byte lane(s) and sign- or zero-extends them.
- Returns the result with an exception code; successor to the combinational extender, adding lane selection, bus handshakes, timeout and fault reporting.

Parameters:
- ADDR_W, 32, byte-address width; bus addresses carry ADDR_W bits with [1:0] forced to 0.
- TIMEOUT, 16, maximum cycles spent in a WAIT state before an access fault; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit idle, can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_op  in  `MEM_EXT_OP_WIDTH  extension op: `MEM_EXT_B/BU/H/HU/W; any other value is illegal.
- bus_req_valid  out  1  word read request.
- bus_req_ready  in  1  bus accepts the request.
- bus_req_addr  out  ADDR_W  word-aligned read address.
- bus_rsp_valid  in  1  single-cycle read-data pulse.
- bus_rsp_data  in  32  read data.
- bus_rsp_err  in  1  bus error, qualified by bus_rsp_valid.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  extended load data; 0 when resp_exc != 0.
- resp_exc  out  2  exception code: 0 = none, 1 = misaligned, 2 = access fault, 3 = illegal op.

Behaviour:
- Reset values: req_ready=1, bus_req_valid=0, bus_req_addr=0, resp_valid=0, resp_data=0, resp_exc=0, state=IDLE, counter=0.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - req_ready=1; a request is accepted when req_valid&&req_ready, and op, addr and offset=addr[1:0] are latched.
  - Illegal op goes to RESP with exc=3.
  - Misaligned (see Optional Feature) goes to RESP with exc=1.
  - Otherwise goes to REQ0.
  - No bus request is issued for exc=1 or exc=3.
- REQ0 / REQ1:
  - bus_req_valid=1, bus_req_addr = {addr[ADDR_W-1:2],2'b00} in REQ0 and that value +4 in REQ1 (wraps modulo 2^ADDR_W).
  - bus_req_addr and bus_req_valid are held stable until bus_req_ready, then the unit moves to WAITx.
- WAIT0 / WAIT1:
  - Counter is cleared on entry and increments each cycle without a response.
  - bus_rsp_valid&&bus_rsp_err goes to RESP with exc=2.
  - bus_rsp_valid alone captures word0/word1, then goes to REQ1 (split needed) or RESP.
  - counter==TIMEOUT-1 with no response (TIMEOUT>0) goes to RESP with exc=2.
- RESP:
  - resp_valid=1; resp_data and resp_exc are held until resp_ready, then the unit returns to IDLE.
  - req_ready=0 in every state except IDLE.
- Extraction:
  - merged = {word1,word0} >> (offset*8), where word1=0 if not fetched.
  - B/BU take merged[7:0] with sign/zero extension to 32 bits.
  - H/HU take merged[15:0] with sign/zero extension.
  - W takes merged[31:0].
- Latency: for an aligned load with bus_req_ready=1 and bus_rsp_valid on the first WAIT cycle, accept at cycle N gives resp_valid at N+3; a split load gives N+5.
- A bus_rsp_valid outside WAIT0/WAIT1 is ignored.
- rst asserted mid-operation aborts the transaction: the unit is in IDLE on the next cycle with bus_req_valid=0, and any late response is ignored.
- Back-to-back: the earliest next acceptance is the cycle after the resp handshake.

Optional Feature:
- Macro: LOAD_ALIGN_MISALIGNED_SPLIT_EN.
- Defined:
  - H/HU with addr[0]=1 and W with addr[1:0]!=0 are served, not trapped.
  - The access is split into two bus reads when offset+size>4 (H at offset 3; W at offset 1–3); otherwise a single read is used.
- Undefined:
  - H/HU with addr[0]=1 and W with addr[1:0]!=0 give exc=1 with no bus access.
  - REQ1/WAIT1 are unreachable and word1 is always 0.

Test Plan:
- Aligned word: LW at 0x100, bus returns 0x8765_4321 in the first WAIT cycle -> resp_data=0x8765_4321, exc=0, resp_valid exactly 3 cycles after accept.
- Byte lanes: bus word 0x80FF_7F01; LB at offset 3 -> 0xFFFF_FF80; LBU at offset 3 -> 0x0000_0080; LB at offset 1 -> 0x0000_007F; LHU at offset 2 -> 0x0000_80FF.
- Misaligned LW at 0x103:
  - Macro undefined -> exc=1, data=0, bus_req_valid never asserted.
  - Macro defined -> reads at 0x100 (0x4433_2211) and 0x104 (0x8877_6655) -> data=0x7766_5544.
- Fault paths:
  - bus_rsp_err=1 on the response -> exc=2, data=0.
  - No response with TIMEOUT=16 -> exc=2 after 16 WAIT cycles.
  - req_op=7 -> exc=3.
- Backpressure and stall: bus_req_ready low 4 cycles -> bus_req_addr stable throughout; resp_ready low 5 cycles -> resp_data stable and req_ready=0.
- Reset mid-op: rst pulsed during WAIT0 -> next cycle IDLE, req_ready=1; a subsequent bus_rsp_valid produces no resp_valid.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit: sequential load-return unit.
// Takes a byte-addressed load from MEM, performs word reads on the data bus,
// extracts and sign/zero-extends the addressed lanes, and returns the result
// together with an exception code (0 none, 1 misaligned, 2 access fault,
// 3 illegal op).
//
// Optional feature: define LOAD_ALIGN_MISALIGNED_SPLIT_EN to serve misaligned
// H/HU/W loads, splitting into two bus reads when the access crosses a word.
// Without it, misaligned H/HU/W loads trap with exc=1 and no bus access.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             load request handshake
//   req_addr, req_op                byte address, extension op
//   bus_req_valid/bus_req_ready     word read request handshake
//   bus_req_addr                    word-aligned read address
//   bus_rsp_valid/data/err          single-cycle read response
//   resp_valid/resp_ready           result handshake
//   resp_data, resp_exc             extended data, exception code

`ifndef MEM_EXT_OP_WIDTH
`define MEM_EXT_OP_WIDTH 3
`define MEM_EXT_B  3'b000
`define MEM_EXT_H  3'b001
`define MEM_EXT_W  3'b010
`define MEM_EXT_BU 3'b100
`define MEM_EXT_HU 3'b101
`endif

module load_align_unit #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [`MEM_EXT_OP_WIDTH-1:0] req_op,
   output logic                         bus_req_valid,
   input  logic                         bus_req_ready,
   output logic [ADDR_W-1:0]            bus_req_addr,
   input  logic                         bus_rsp_valid,
   input  logic [31:0]                  bus_rsp_data,
   input  logic                         bus_rsp_err,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [31:0]                  resp_data,
   output logic [1:0]                   resp_exc
);

   localparam int unsigned OP_W = `MEM_EXT_OP_WIDTH;

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

   state_t            state;
   logic [OP_W-1:0]   op_q;
   logic [1:0]        off_q;
   logic              split_q;
   logic [31:0]       word0_q;
   logic [CNT_W-1:0]  cnt_q;

   // Lane extraction from the two-word window shifted by the byte offset.
   function automatic logic [31:0] extract(input logic [OP_W-1:0] op,
                                           input logic [1:0]      off,
                                           input logic [63:0]     words);
      logic [63:0] merged;
      merged = words >> {off, 3'b000};
      case (op)
         `MEM_EXT_B:  extract = {{24{merged[7]}}, merged[7:0]};
         `MEM_EXT_BU: extract = {24'd0, merged[7:0]};
         `MEM_EXT_H:  extract = {{16{merged[15]}}, merged[15:0]};
         `MEM_EXT_HU: extract = {16'd0, merged[15:0]};
         `MEM_EXT_W:  extract = merged[31:0];
         default:     extract = 32'd0;
      endcase
   endfunction

   // Request classification at acceptance.
   logic is_half_c, is_word_c, illegal_c, misaligned_c, split_c, timeout_c;

   always_comb begin
      is_half_c = (req_op == `MEM_EXT_H) || (req_op == `MEM_EXT_HU);
      is_word_c = (req_op == `MEM_EXT_W);
      illegal_c = !(is_half_c || is_word_c ||
                    (req_op == `MEM_EXT_B) || (req_op == `MEM_EXT_BU));
`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
      misaligned_c = 1'b0;
      split_c      = (is_half_c && (req_addr[1:0] == 2'b11)) ||
                     (is_word_c && (req_addr[1:0] != 2'b00));
`else
      misaligned_c = (is_half_c && req_addr[0]) ||
                     (is_word_c && (req_addr[1:0] != 2'b00));
      split_c      = 1'b0;
`endif
      timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   // Main FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         bus_req_valid <= 1'b0;
         bus_req_addr  <= '0;
         resp_valid    <= 1'b0;
         resp_data     <= 32'd0;
         resp_exc      <= 2'd0;
         op_q          <= '0;
         off_q         <= 2'd0;
         split_q       <= 1'b0;
         word0_q       <= 32'd0;
         cnt_q         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  op_q      <= req_op;
                  off_q     <= req_addr[1:0];
                  split_q   <= split_c;
                  req_ready <= 1'b0;
                  if (illegal_c || misaligned_c) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= 32'd0;
                     resp_exc   <= illegal_c ? 2'd3 : 2'd1;
                  end else begin
                     state         <= REQ0;
                     bus_req_valid <= 1'b1;
                     bus_req_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            REQ0, REQ1: begin
               if (bus_req_ready) begin
                  bus_req_valid <= 1'b0;
                  cnt_q         <= '0;
                  state         <= (state == REQ0) ? WAIT0 : WAIT1;
               end
            end
            WAIT0, WAIT1: begin
               if (bus_rsp_valid) begin
                  if (bus_rsp_err) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= 32'd0;
                     resp_exc   <= 2'd2;
                  end else if ((state == WAIT0) && split_q) begin
                     // Second word follows the first, wrapping at the top.
                     word0_q       <= bus_rsp_data;
                     state         <= REQ1;
                     bus_req_valid <= 1'b1;
                     bus_req_addr  <= bus_req_addr + ADDR_W'(4);
                  end else begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_exc   <= 2'd0;
                     resp_data  <= (state == WAIT0) ?
                                   extract(op_q, off_q, {32'd0, bus_rsp_data}) :
                                   extract(op_q, off_q, {bus_rsp_data, word0_q});
                  end
               end else if (timeout_c) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_data  <= 32'd0;
                  resp_exc   <= 2'd2;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed loads push expected results,
// a negedge monitor pops and compares on every result handshake.
`timescale 1ns/1ps
module tb_load_align_unit;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_op;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic [31:0] bus_req_addr;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_data;
   logic        bus_rsp_err;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [1:0]  resp_exc;

   load_align_unit dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_op        (req_op),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_req_addr  (bus_req_addr),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_data  (bus_rsp_data),
      .bus_rsp_err   (bus_rsp_err),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_exc      (resp_exc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  exc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   acc_cycle = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result monitor: handshake completes at the following posedge.
   always @(negedge clk) begin
      if (!rst && resp_valid && resp_ready) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_resp data=%h exc=%0d", resp_data, resp_exc);
         end else begin
            mon_e = q.pop_front();
            if (resp_data !== mon_e.data || resp_exc !== mon_e.exc) begin
               failures++;
               $display("FAIL resp actual=%h/%0d expected=%h/%0d",
                        resp_data, resp_exc, mon_e.data, mon_e.exc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send_req(input logic [31:0] a, input logic [2:0] op,
                           input logic [31:0] ed, input logic [1:0] ee, input bit push);
      int n;
      exp_t e;
      n = 0;
      req_valid = 1'b1; req_addr = a; req_op = op;
      while (!req_ready && n < 20) begin step(); n++; end
      chk("req_ready_at_issue", 32'(req_ready), 32'd1);
      if (push) begin
         e.data = ed; e.exc = ee;
         q.push_back(e);
      end
      acc_cycle = cyc + 1;
      step();
      req_valid = 1'b0;
   endtask

   task automatic serve(input logic [31:0] exp_addr, input logic [31:0] word,
                        input logic err, input int rdy_delay);
      int n;
      logic [31:0] a0;
      n = 0;
      while (!bus_req_valid && n < 20) begin step(); n++; end
      chk("bus_req_valid", 32'(bus_req_valid), 32'd1);
      chk("bus_req_addr", bus_req_addr, exp_addr);
      a0 = bus_req_addr;
      for (int i = 0; i < rdy_delay; i++) begin
         step();
         chk("bus_addr_stable", bus_req_addr, a0);
         chk("bus_valid_stable", 32'(bus_req_valid), 32'd1);
      end
      bus_req_ready = 1'b1;
      step();
      bus_req_ready = 1'b0;
      chk("bus_valid_drop", 32'(bus_req_valid), 32'd0);
      bus_rsp_valid = 1'b1; bus_rsp_data = word; bus_rsp_err = err;
      step();
      bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rsp_data = 32'hA5A5_A5A5;
   endtask

   task automatic wait_resp(input int exp_lat, input int stall, input bit nobus);
      int n;
      logic [31:0] d;
      logic [1:0]  e;
      n = 0;
      if (nobus) chk("no_bus_req", 32'(bus_req_valid), 32'd0);
      while (!resp_valid && n < 40) begin step(); n++; end
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("latency", 32'(cyc + 1 - acc_cycle), 32'(exp_lat));
      d = resp_data; e = resp_exc;
      for (int i = 0; i < stall; i++) begin
         chk("req_ready_in_resp", 32'(req_ready), 32'd0);
         step();
         chk("resp_data_stable", resp_data, d);
         chk("resp_exc_stable", 32'(resp_exc), 32'(e));
         chk("resp_valid_held", 32'(resp_valid), 32'd1);
         if (nobus) chk("no_bus_req", 32'(bus_req_valid), 32'd0);
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk("idle_after_resp", 32'(req_ready), 32'd1);
      chk("resp_valid_drop", 32'(resp_valid), 32'd0);
   endtask

   task automatic load1(input logic [31:0] a, input logic [2:0] op,
                        input logic [31:0] word, input logic [31:0] ed);
      send_req(a, op, ed, 2'd0, 1'b1);
      serve({a[31:2], 2'b00}, word, 1'b0, 0);
      wait_resp(3, 0, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_op = 3'd0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 32'd0;
      bus_rsp_err = 1'b0; resp_ready = 1'b0;
      step(); step();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_bus_req_valid", 32'(bus_req_valid), 32'd0);
      chk("rst_bus_req_addr", bus_req_addr, 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_exc", 32'(resp_exc), 32'd0);
      rst = 1'b0;
      step();

      // Aligned word, first-cycle response.
      load1(32'h100, OP_W, 32'h8765_4321, 32'h8765_4321);

      // Byte and half lanes from one bus word.
      load1(32'h203, OP_B,  32'h80FF_7F01, 32'hFFFF_FF80);
      load1(32'h203, OP_BU, 32'h80FF_7F01, 32'h0000_0080);
      load1(32'h201, OP_B,  32'h80FF_7F01, 32'h0000_007F);
      load1(32'h202, OP_HU, 32'h80FF_7F01, 32'h0000_80FF);
      load1(32'h202, OP_H,  32'h80FF_7F01, 32'hFFFF_80FF);
      load1(32'h200, OP_H,  32'h80FF_7F01, 32'h0000_7F01);
      load1(32'h200, OP_BU, 32'h80FF_7F01, 32'h0000_0001);

`ifdef LOAD_ALIGN_MISALIGNED_SPLIT_EN
      // Split word across 0x100/0x104.
      send_req(32'h103, OP_W, 32'h7766_5544, 2'd0, 1'b1);
      serve(32'h100, 32'h4433_2211, 1'b0, 0);
      serve(32'h104, 32'h8877_6655, 1'b0, 0);
      wait_resp(5, 0, 1'b0);
      // Odd half within one word: single read.
      load1(32'h101, OP_H, 32'h4433_2211, 32'h0000_3322);
      // Half at offset 3 crosses words.
      send_req(32'h103, OP_HU, 32'h0000_5544, 2'd0, 1'b1);
      serve(32'h100, 32'h4433_2211, 1'b0, 0);
      serve(32'h104, 32'h8877_6655, 1'b0, 2);
      wait_resp(7, 0, 1'b0);
      // Second read address wraps past the top of memory.
      send_req(32'hFFFF_FFFE, OP_W, 32'h6655_4433, 2'd0, 1'b1);
      serve(32'hFFFF_FFFC, 32'h4433_2211, 1'b0, 0);
      serve(32'h0000_0000, 32'h8877_6655, 1'b0, 0);
      wait_resp(5, 0, 1'b0);
`else
      // Misaligned accesses trap without touching the bus.
      send_req(32'h103, OP_W, 32'h0, 2'd1, 1'b1);
      wait_resp(1, 2, 1'b1);
      send_req(32'h101, OP_H, 32'h0, 2'd1, 1'b1);
      wait_resp(1, 0, 1'b1);
      send_req(32'h103, OP_HU, 32'h0, 2'd1, 1'b1);
      wait_resp(1, 0, 1'b1);
`endif

      // Bus error on response.
      send_req(32'h300, OP_W, 32'h0, 2'd2, 1'b1);
      serve(32'h300, 32'hDEAD_BEEF, 1'b1, 0);
      wait_resp(3, 0, 1'b0);

      // No response: 16 WAIT cycles then access fault.
      send_req(32'h400, OP_W, 32'h0, 2'd2, 1'b1);
      begin
         int n;
         n = 0;
         while (!bus_req_valid && n < 20) begin step(); n++; end
         chk("to_bus_req_addr", bus_req_addr, 32'h400);
         bus_req_ready = 1'b1;
         step();
         bus_req_ready = 1'b0;
      end
      wait_resp(18, 0, 1'b0);

      // Illegal ops.
      send_req(32'h500, 3'd7, 32'h0, 2'd3, 1'b1);
      wait_resp(1, 0, 1'b1);
      send_req(32'h500, 3'd3, 32'h0, 2'd3, 1'b1);
      wait_resp(1, 0, 1'b1);
      send_req(32'h500, 3'd6, 32'h0, 2'd3, 1'b1);
      wait_resp(1, 0, 1'b1);

      // Bus request backpressure and result stall.
      send_req(32'h600, OP_W, 32'h1234_5678, 2'd0, 1'b1);
      serve(32'h600, 32'h1234_5678, 1'b0, 4);
      wait_resp(7, 5, 1'b0);

      // Stray response while idle is ignored.
      bus_rsp_valid = 1'b1; bus_rsp_data = 32'h1111_1111;
      step();
      bus_rsp_valid = 1'b0;
      step();
      chk("stray_rsp_no_resp", 32'(resp_valid), 32'd0);
      chk("stray_rsp_idle", 32'(req_ready), 32'd1);

      // Reset during WAIT0 aborts; a late response is ignored.
      send_req(32'h700, OP_W, 32'h0, 2'd0, 1'b0);
      begin
         int n;
         n = 0;
         while (!bus_req_valid && n < 20) begin step(); n++; end
         bus_req_ready = 1'b1;
         step();
         bus_req_ready = 1'b0;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_bus_req_valid", 32'(bus_req_valid), 32'd0);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      bus_rsp_valid = 1'b1; bus_rsp_data = 32'h2222_2222;
      step();
      bus_rsp_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("late_rsp_no_resp", 32'(resp_valid), 32'd0);
         step();
      end

      // Unit still works after the abort.
      load1(32'h800, OP_W, 32'hCAFE_F00D, 32'hCAFE_F00D);

      step(); step();
      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
